pulse_stretcher: RTL and testbench

- Inverse of the press-to-pulse path: converts single-cycle event strobes into clean, timed level pulses (HIGH_CYCLES high, then at least LOW_CYCLES low) for LEDs or for a downstream edge detector.
- Events arriving while a pulse is in progress are queued in a saturating pending counter, so each strobe produces exactly one output pulse.
- Used for visible status blinks and for loopback checking of the input-side edge detection in the signed multiplier top level.

---
 rtl/pulse_stretcher_pkg.sv | 14 +
 rtl/pulse_stretcher_sat_counter.sv | 30 +++
 rtl/pulse_stretcher.sv | 93 +++++++++
 tb/tb_pulse_stretcher.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/pulse_stretcher_pkg.sv
// Shared types and defaults for the pulse stretcher.
// The 2-bit state encoding matches the edge detector's style.
package pulse_stretcher_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    HIGH = 2'b01,
    LOW  = 2'b10
  } state_t;

  localparam int unsigned LED_HIGH_CYCLES = 4;
  localparam int unsigned LED_LOW_CYCLES  = 2;

endpackage

// File: rtl/pulse_stretcher_sat_counter.sv
// Up/down saturating counter with a sticky overflow flag.
// Simultaneous inc and dec cancel out.
module sat_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         overflow
);

  localparam logic [W-1:0] CNT_MAX = {W{1'b1}};
  localparam logic [W-1:0] ONE     = W'(1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count    <= '0;
      overflow <= 1'b0;
    end else if (inc && !dec) begin
      // An event arriving at saturation is dropped and remembered.
      if (count == CNT_MAX) overflow <= 1'b1;
      else                  count    <= count + ONE;
    end else if (dec && !inc && (count != '0)) begin
      count <= count - ONE;
    end
  end

endmodule

// File: rtl/pulse_stretcher.sv
// Turns single-cycle strobes into timed level pulses separated by a fixed low gap.
// Strobes arriving during a pulse are queued in a saturating pending counter.
module pulse_stretcher
  import pulse_stretcher_pkg::*;
#(
  parameter int unsigned HIGH_CYCLES = LED_HIGH_CYCLES,
  parameter int unsigned LOW_CYCLES  = LED_LOW_CYCLES,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned PEND_W      = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              p,
  output logic              z,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  localparam logic [CNT_W-1:0] HIGH_LOAD = CNT_W'(HIGH_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOW_LOAD  = CNT_W'(LOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] timer;
  logic             low_exit;
  logic             pend_inc;
  logic             pend_dec;

  // An event seen in IDLE or at an empty LOW exit starts a pulse directly.
  assign low_exit = (state == LOW) && (timer == '0);
  assign pend_inc = p && (state != IDLE) && !(low_exit && (pending == '0));
  assign pend_dec = low_exit && (pending != '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      timer <= '0;
      z     <= 1'b0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (p) begin
            state <= HIGH;
            timer <= HIGH_LOAD;
            z     <= 1'b1;
            busy  <= 1'b1;
          end
        end
        HIGH: begin
          if (timer != '0) begin
            timer <= timer - ONE;
          end else begin
            state <= LOW;
            timer <= LOW_LOAD;
            z     <= 1'b0;
          end
        end
        LOW: begin
          if (timer != '0) begin
            timer <= timer - ONE;
          end else if ((pending != '0) || p) begin
            state <= HIGH;
            timer <= HIGH_LOAD;
            z     <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          timer <= '0;
          z     <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  sat_counter #(
    .W(PEND_W)
  ) u_pend (
    .clock   (clock),
    .reset   (reset),
    .inc     (pend_inc),
    .dec     (pend_dec),
    .count   (pending),
    .overflow(overflow)
  );

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed bench for pulse_stretcher: default instance plus a PEND_W=2 instance
// for saturation. Cycle n is the period following rising edge n-1.
module tb_pulse_stretcher;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       p     = 1'b0;
  logic       p2    = 1'b0;
  logic       z, busy, overflow;
  logic [3:0] pending;
  logic       z2, busy2, overflow2;
  logic [1:0] pending2;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  pulse_stretcher dut (
    .clock   (clock),
    .reset   (reset),
    .p       (p),
    .z       (z),
    .busy    (busy),
    .pending (pending),
    .overflow(overflow)
  );

  pulse_stretcher #(.PEND_W(2)) dut_sat (
    .clock   (clock),
    .reset   (reset),
    .p       (p2),
    .z       (z2),
    .busy    (busy2),
    .pending (pending2),
    .overflow(overflow2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    p     = 1'b0;
    p2    = 1'b0;
    tick();
    reset = 1'b0;
    tick();
  endtask

  int prev;
  int rises;

  initial begin
    // Reset state
    #2;
    chk("rst_z", 32'(z), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_pending", 32'(pending), 0);
    chk("rst_overflow", 32'(overflow), 0);
    do_reset();

    // Single event at edge 0
    p = 1'b1; tick(); p = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      chk($sformatf("single_z_c%0d", c), 32'(z), 32'(c <= 4));
      chk($sformatf("single_busy_c%0d", c), 32'(busy), 32'(c <= 6));
      tick();
    end
    do_reset();

    // Events at edges 0,1,2
    p = 1'b1; tick(); tick(); tick(); p = 1'b0;
    chk("three_pending", 32'(pending), 2);
    for (int c = 3; c <= 19; c++) begin
      chk($sformatf("three_z_c%0d", c), 32'(z),
          32'((c <= 4) || (c >= 7 && c <= 10) || (c >= 13 && c <= 16)));
      if (c == 19) chk("three_idle", 32'(busy), 0);
      tick();
    end
    chk("three_overflow", 32'(overflow), 0);
    do_reset();

    // Event coincident with final LOW cycle (edge 6)
    for (int c = 1; c <= 13; c++) begin
      p = (c == 1) || (c == 7);
      tick();
      p = 1'b0;
      chk($sformatf("coin_z_c%0d", c), 32'(z), 32'((c <= 4) || (c >= 7 && c <= 10)));
      chk($sformatf("coin_pend_c%0d", c), 32'(pending), 0);
    end
    chk("coin_idle", 32'(busy), 0);
    do_reset();

    // Asynchronous reset during HIGH with one event queued
    p = 1'b1; tick(); tick(); p = 1'b0;
    chk("mid_pre_z", 32'(z), 1);
    chk("mid_pre_pending", 32'(pending), 1);
    #2 reset = 1'b1;
    #1;
    chk("mid_z", 32'(z), 0);
    chk("mid_busy", 32'(busy), 0);
    chk("mid_pending", 32'(pending), 0);
    chk("mid_overflow", 32'(overflow), 0);
    tick();
    reset = 1'b0;
    tick(); tick();
    chk("mid_after_z", 32'(z), 0);
    chk("mid_after_busy", 32'(busy), 0);

    // Saturation on PEND_W=2: p high for edges 0..5
    prev  = 0;
    rises = 0;
    for (int c = 0; c < 40; c++) begin
      p2 = (c < 6);
      tick();
      if (z2 && prev == 0) rises++;
      prev = int'(z2);
      if (c == 5) begin
        chk("sat_pending", 32'(pending2), 3);
        chk("sat_overflow", 32'(overflow2), 1);
      end
    end
    p2 = 1'b0;
    chk("sat_pulses", 32'(rises), 4);
    chk("sat_overflow_sticky", 32'(overflow2), 1);
    chk("sat_idle", 32'(busy2), 0);
    do_reset();
    chk("sat_overflow_cleared", 32'(overflow2), 0);

    // Loopback: count rising edges of z over 20 sparse strobes
    prev  = 0;
    rises = 0;
    for (int i = 0; i < 20; i++) begin
      p = 1'b1;
      for (int g = 0; g < 8 + (i % 4); g++) begin
        tick();
        p = 1'b0;
        if (z && prev == 0) rises++;
        prev = int'(z);
      end
    end
    for (int g = 0; g < 10; g++) begin
      tick();
      if (z && prev == 0) rises++;
      prev = int'(z);
    end
    chk("loop_pulses", 32'(rises), 20);
    chk("loop_overflow", 32'(overflow), 0);
    chk("loop_idle", 32'(busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
